// File: rtl/wb_trace_buffer.sv
// Writeback trace capture: FIFO of {dr, val} records drained by a valid/ready reader,
// plus saturating counters for writebacks, stall cycles and branch-taken cycles.
module wb_trace_buffer #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic                     CLOCK_50,
   input  logic                     KEY0,
   input  logic                     wb_en,
   input  logic [2:0]               wb_dr,
   input  logic [15:0]              wb_val,
   input  logic                     stall,
   input  logic                     branch,
   input  logic                     freeze,
   input  logic                     clr,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output logic [18:0]              rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     overflow,
   output logic [CNT_W-1:0]         wb_count,
   output logic [CNT_W-1:0]         stall_count,
   output logic [CNT_W-1:0]         branch_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic              overflow_q, overflow_d;
   logic [CNT_W-1:0]  wb_count_q, wb_count_d;
   logic [CNT_W-1:0]  stall_count_q, stall_count_d;
   logic [CNT_W-1:0]  branch_count_q, branch_count_d;
   logic [18:0]       mem_q [DEPTH];

   logic empty, full_int, push, pop, store, drop;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && v != CNT_MAX) ? v + CNT_W'(1) : v;
   endfunction

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full_int = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      push     = wb_en & ~freeze;
      pop      = ~empty & rd_ready;
      // A pop in the same cycle frees the slot, so a push at full still lands.
      store    = push & (~full_int | pop);
      drop     = push & full_int & ~pop;

      wr_ptr_d = store ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

      overflow_d     = overflow_q;
      wb_count_d     = wb_count_q;
      stall_count_d  = stall_count_q;
      branch_count_d = branch_count_q;
      if (clr) begin
         overflow_d     = 1'b0;
         wb_count_d     = '0;
         stall_count_d  = '0;
         branch_count_d = '0;
      end else begin
         overflow_d     = overflow_q | drop;
         wb_count_d     = sat_inc(wb_count_q, push);
         stall_count_d  = sat_inc(stall_count_q, stall & ~freeze);
         branch_count_d = sat_inc(branch_count_q, branch & ~freeze);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!KEY0) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         overflow_q     <= 1'b0;
         wb_count_q     <= '0;
         stall_count_q  <= '0;
         branch_count_q <= '0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         overflow_q     <= overflow_d;
         wb_count_q     <= wb_count_d;
         stall_count_q  <= stall_count_d;
         branch_count_q <= branch_count_d;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (KEY0 && store) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {wb_dr, wb_val};
      end
   end

   // Read is decoded straight from the head slot; masked so an empty FIFO shows zero.
   assign rd_valid     = ~empty;
   assign rd_data      = empty ? 19'd0 : mem_q[rd_ptr_q[AW-1:0]];
   assign level        = wr_ptr_q - rd_ptr_q;
   assign full         = full_int;
   assign overflow     = overflow_q;
   assign wb_count     = wb_count_q;
   assign stall_count  = stall_count_q;
   assign branch_count = branch_count_q;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: driver models FIFO/counters as a queue and integers,
// a negedge monitor compares every DUT output and pops the expected-entry queue on each read.
module tb_wb_trace_buffer;
   localparam int DEPTH = 16;
   localparam int CNT_W = 6;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic              CLOCK_50;
   logic              KEY0, wb_en, stall, branch, freeze, clr, rd_ready;
   logic [2:0]        wb_dr;
   logic [15:0]       wb_val;
   logic              rd_valid, full, overflow;
   logic [18:0]       rd_data;
   logic [LW-1:0]     level;
   logic [CNT_W-1:0]  wb_count, stall_count, branch_count;

   int         n_checks = 0;
   int         n_err    = 0;
   logic [18:0] exp_q[$];
   int         m_wb, m_stall, m_br;
   bit         m_ovf;
   bit         armed = 0;

   wb_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .CLOCK_50(CLOCK_50), .KEY0(KEY0), .wb_en(wb_en), .wb_dr(wb_dr), .wb_val(wb_val),
      .stall(stall), .branch(branch), .freeze(freeze), .clr(clr), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .level(level), .full(full),
      .overflow(overflow), .wb_count(wb_count), .stall_count(stall_count),
      .branch_count(branch_count)
   );

   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare registered outputs mid-cycle; a read handshake consumes the head.
   always @(negedge CLOCK_50) begin
      if (armed) begin
         check("rd_valid", rd_valid, exp_q.size() != 0);
         check("level", level, exp_q.size());
         check("full", full, exp_q.size() == DEPTH);
         check("overflow", overflow, m_ovf);
         check("wb_count", wb_count, m_wb);
         check("stall_count", stall_count, m_stall);
         check("branch_count", branch_count, m_br);
         if (rd_valid && exp_q.size() != 0) check("rd_data", rd_data, exp_q[0]);
         if (rd_valid && rd_ready && KEY0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_entry", 1, 0);
            end else begin
               $display("pop dr=%0d val=%04h level=%0d", rd_data[18:16], rd_data[15:0], level);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // Drive one cycle of stimulus, then advance the reference model across that edge.
   task automatic cycle(input bit k, input bit we, input logic [2:0] dr, input logic [15:0] v,
                        input bit st, input bit br, input bit fr, input bit cl, input bit rr);
      int lvl;
      bit pop_e, push_e;
      KEY0 = k; wb_en = we; wb_dr = dr; wb_val = v;
      stall = st; branch = br; freeze = fr; clr = cl; rd_ready = rr;
      lvl    = exp_q.size();
      pop_e  = k && rr && (lvl > 0);
      push_e = k && we && !fr;
      @(posedge CLOCK_50);
      if (!k) begin
         exp_q.delete();
         m_wb = 0; m_stall = 0; m_br = 0; m_ovf = 0;
         armed = 1;
      end else begin
         if (push_e && (lvl < DEPTH || pop_e)) exp_q.push_back({dr, v});
         if (cl) begin
            m_wb = 0; m_stall = 0; m_br = 0; m_ovf = 0;
         end else begin
            if (push_e && lvl == DEPTH && !pop_e) m_ovf = 1;
            if (push_e && m_wb < CMAX) m_wb++;
            if (st && !fr && m_stall < CMAX) m_stall++;
            if (br && !fr && m_br < CMAX) m_br++;
         end
      end
      #1;
   endtask

   task automatic idle(input bit rr);
      cycle(1, 0, 3'd0, 16'd0, 0, 0, 0, 0, rr);
   endtask

   initial begin
      KEY0 = 0; wb_en = 0; wb_dr = 0; wb_val = 0;
      stall = 0; branch = 0; freeze = 0; clr = 0; rd_ready = 0;

      cycle(0, 0, 3'd0, 16'd0, 0, 0, 0, 0, 0);
      cycle(0, 0, 3'd0, 16'd0, 0, 0, 0, 0, 0);
      check("reset_rd_data", rd_data, 0);
      idle(0);

      cycle(1, 1, 3'd3, 16'h00A5, 0, 0, 0, 0, 0);
      check("single_rd_data", rd_data, 19'h300A5);
      idle(0);
      idle(1);
      idle(0);

      for (int i = 0; i < 17; i++) cycle(1, 1, 3'(i), 16'(i), 0, 0, 0, 0, 0);
      idle(0);
      cycle(1, 1, 3'd7, 16'hBEEF, 0, 0, 0, 0, 1);
      for (int i = 0; i < 18; i++) idle(1);

      for (int i = 0; i < 5; i++) cycle(1, 0, 3'd0, 16'd0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) cycle(1, 0, 3'd0, 16'd0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, 0, 3'd0, 16'd0, 1, 1, 1, 0, 0);
      cycle(1, 1, 3'd5, 16'h1234, 0, 0, 1, 0, 0);
      cycle(1, 0, 3'd0, 16'd0, 1, 0, 0, 1, 0);
      idle(0);

      for (int i = 0; i < CMAX + 6; i++) cycle(1, 0, 3'd0, 16'd0, 1, 0, 0, 0, 0);
      idle(0);

      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 99) != 0),
               ($urandom_range(0, 1) == 1),
               3'($urandom),
               16'($urandom),
               ($urandom_range(0, 9) < 4),
               ($urandom_range(0, 9) < 3),
               ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 49) == 0),
               ($urandom_range(0, 9) < 4));
      end
      for (int i = 0; i < DEPTH + 2; i++) idle(1);
      @(negedge CLOCK_50);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Debug capture block sitting directly downstream of the five-stage processor's observation outputs. Records every register writeback (destination register plus value) into a FIFO that a host-side reader drains through a valid/ready handshake. Also keeps saturating event counters for writebacks, stall cycles and branch-taken cycles. Lets the bench or a board-level readout reconstruct the retired-result stream without probing pipeline internals.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 2.
- CNT_W, 16: width of each event counter.

Ports:
- CLOCK_50  in  1  sole clock; all state updates on its rising edge.
- KEY0  in  1  reset; synchronous, active-low (0 = reset), sampled on CLOCK_50.
- wb_en  in  1  processor writeback enable for this cycle.
- wb_dr  in  3  writeback destination register.
- wb_val  in  16  writeback value.
- stall  in  1  processor decode stall indication.
- branch  in  1  processor branch-taken indication from execute.
- freeze  in  1  1 = suspend capture and counting.
- clr  in  1  clears counters and the overflow flag.
- rd_ready  in  1  reader accepts the head entry.
- rd_valid  out  1  FIFO non-empty; rd_data is valid.
- rd_data  out  19  head entry, packed as {dr[2:0], val[15:0]}.
- level  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- overflow  out  1  sticky; set when a writeback is dropped.
- wb_count  out  CNT_W  captured-writeback count.
- stall_count  out  CNT_W  stall-cycle count.
- branch_count  out  CNT_W  branch-cycle count.

## Operation
- Capture: push = wb_en & ~freeze. A push writes {wb_dr, wb_val} at the write pointer.
- Pop: pop = rd_valid & rd_ready. A pop advances the read pointer.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. full and empty derive from the pointer MSB and the remaining bits. level = wr_ptr − rd_ptr.
- Full FIFO, push without pop: entry is dropped, pointers are unchanged, overflow ← 1.
- Full FIFO, push with pop in the same cycle: both occur, level stays DEPTH, no overflow.
- Empty FIFO, push (a pop is impossible): entry is stored. There is no bypass to rd_data in the same cycle.
- Push and pop in the same cycle on a non-empty, non-full FIFO: both occur, level unchanged.
- The read side is first-word-fall-through: rd_data always shows the head entry. rd_data is don't-care when rd_valid = 0.
- Counters:
  - When ~freeze, wb_count increments on push.
  - When ~freeze, stall_count increments each cycle stall = 1.
  - When ~freeze, branch_count increments each cycle branch = 1.
  - All counters saturate at 2^CNT_W − 1 and never wrap.
- clr: counters ← 0 and overflow ← 0. clr overrides any increment in the same cycle. clr does not affect FIFO contents or pointers. A drop in the same cycle as clr leaves overflow = 0.
- freeze: blocks pushes, counting and overflow setting. Pops continue normally.

## Timing
- Reset (KEY0 = 0 at an edge): pointers ← 0, rd_valid = 0, level = 0, full = 0, overflow = 0, all counters = 0, rd_data = 0. Reset overrides push, pop and clr.
- Reset asserted mid-drain discards all entries. The first post-reset push appears with rd_valid = 1 one cycle later.
- Push latency: an entry captured at edge N is visible at rd_data/rd_valid after edge N (one-cycle latency). level and full update at the same edge.
- Pop: the head is consumed at the edge where rd_valid & rd_ready. The next entry (or rd_valid = 0) is visible after that edge.
- Counter and overflow outputs are registered and reflect events up to and including the previous edge.
- No combinational path from rd_ready to rd_valid or rd_data. All outputs are register-driven or decoded from registers.

## Test plan
- Reset then idle: hold KEY0 = 0 for 2 cycles, then 1 → all outputs 0, rd_valid = 0, level = 0.
- Single capture: wb_en = 1, wb_dr = 3, wb_val = 16'h00A5 for one cycle, rd_ready = 0 → next cycle rd_valid = 1, rd_data = 19'h300A5, level = 1, wb_count = 1. Assert rd_ready for 1 cycle → rd_valid = 0, level = 0.
- Fill and overflow (DEPTH = 16): 17 consecutive pushes with values 0..16, rd_ready = 0 → full = 1, level = 16, overflow = 1, wb_count = 17. Draining yields values 0..15 in order; value 16 is lost.
- Simultaneous push/pop at full: at level = 16, push 16'hBEEF with rd_ready = 1 → level stays 16, overflow unchanged. 16'hBEEF is the last entry drained.
- Counters, freeze and clr: stall = 1 for 5 cycles, branch = 1 for 2 cycles → stall_count = 5, branch_count = 2. With freeze = 1, 3 more stall cycles and a wb_en pulse → counts and level unchanged. clr together with stall = 1 → stall_count = 0.
- Saturation (CNT_W = 4): 20 stall cycles → stall_count = 15 and holds.
